// File: rtl/adc_ctrl_pkg.sv
// Shared state encoding and default sizing for the ADC acquisition control slice.
package adc_ctrl_pkg;

  localparam int unsigned DEF_CLEAR_CYCLES = 8;
  localparam int unsigned DEF_CNT_WIDTH    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4
  } acq_state_t;

endpackage

// File: rtl/adc_ctrl_timer.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module adc_ctrl_timer
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_CNT_WIDTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition control FSM: clears, arms and bounds captures of the ADC trigger
// datapath, with optional auto-rearm after a holdoff.
module adc_acq_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned DONE_CNT_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_arm,
  input  logic                      cmd_abort,
  input  logic [CNT_WIDTH-1:0]      cfg_capture_len,
  input  logic [CNT_WIDTH-1:0]      cfg_holdoff,
  input  logic                      cfg_auto_rearm,
  input  logic                      trigger_activated,
  input  logic [CNT_WIDTH-1:0]      limiter,
  output logic                      reset_trigger,
  output logic                      reset_max_sum,
  output logic [2:0]                state,
  output logic                      armed,
  output logic                      busy,
  output logic                      capture_done,
  output logic [DONE_CNT_WIDTH-1:0] capture_count
);

  localparam logic [CNT_WIDTH-1:0] CLEAR_LOAD = CNT_WIDTH'(CLEAR_CYCLES - 1);

  acq_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, holdoff_q;
  logic                 rearm_q;

  logic                 tmr_load, tmr_en, tmr_zero;
  logic [CNT_WIDTH-1:0] tmr_val;
  logic                 arm_accept, cap_end;

  adc_ctrl_timer #(
    .WIDTH(CNT_WIDTH)
  ) u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  // Abort is checked first in every busy state so it wins over all other exits.
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    arm_accept = 1'b0;
    cap_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_arm && !cmd_abort) begin
          arm_accept = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = CLEAR_LOAD;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cmd_abort)     state_d = ST_IDLE;
        else if (tmr_zero) state_d = ST_ARMED;
        else               tmr_en  = 1'b1;
      end
      ST_ARMED: begin
        if (cmd_abort)              state_d = ST_IDLE;
        else if (trigger_activated) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (((len_q != '0) && (limiter >= len_q)) || !trigger_activated) begin
          cap_end = 1'b1;
          if (rearm_q) begin
            tmr_load = 1'b1;
            tmr_val  = holdoff_q;
            state_d  = ST_HOLDOFF;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = CLEAR_LOAD;
          state_d  = ST_CLEAR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      reset_trigger <= 1'b1;
      reset_max_sum <= 1'b0;
      armed         <= 1'b0;
      busy          <= 1'b0;
      capture_done  <= 1'b0;
      capture_count <= '0;
      len_q         <= '0;
      holdoff_q     <= '0;
      rearm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      reset_trigger <= (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_HOLDOFF);
      reset_max_sum <= (state_d == ST_CLEAR);
      armed         <= (state_d == ST_ARMED);
      busy          <= (state_d != ST_IDLE);
      capture_done  <= cap_end;
      if (arm_accept) begin
        len_q         <= cfg_capture_len;
        holdoff_q     <= cfg_holdoff;
        rearm_q       <= cfg_auto_rearm;
        capture_count <= '0;
      end else if (cap_end && (capture_count != '1)) begin
        capture_count <= capture_count + DONE_CNT_WIDTH'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Bench for adc_acq_sequencer: cycle-level phase/duration model plus directed
// scenarios and a randomized run with an emulated trigger datapath.
module tb_adc_acq_sequencer;

  localparam int unsigned CC = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_arm = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [CW-1:0] cfg_capture_len = '0;
  logic [CW-1:0] cfg_holdoff = '0;
  logic          cfg_auto_rearm = 1'b0;
  logic          trigger_activated = 1'b0;
  logic [CW-1:0] limiter = '0;
  logic          reset_trigger, reset_max_sum, armed, busy, capture_done;
  logic [2:0]    state;
  logic [DW-1:0] capture_count;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  adc_acq_sequencer #(
    .CLEAR_CYCLES  (CC),
    .CNT_WIDTH     (CW),
    .DONE_CNT_WIDTH(DW)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cmd_arm          (cmd_arm),
    .cmd_abort        (cmd_abort),
    .cfg_capture_len  (cfg_capture_len),
    .cfg_holdoff      (cfg_holdoff),
    .cfg_auto_rearm   (cfg_auto_rearm),
    .trigger_activated(trigger_activated),
    .limiter          (limiter),
    .reset_trigger    (reset_trigger),
    .reset_max_sum    (reset_max_sum),
    .state            (state),
    .armed            (armed),
    .busy             (busy),
    .capture_done     (capture_done),
    .capture_count    (capture_count)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: phase code and the number of cycles left in the timed phases.
  int unsigned       m_phase = 0;
  longint unsigned   m_left = 0;
  longint unsigned   m_len = 0, m_hold = 0;
  bit                m_rearm = 0, m_done = 0;
  int unsigned       m_count = 0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase = 0; m_left = 0; m_len = 0; m_hold = 0;
      m_rearm = 0; m_done = 0; m_count = 0;
    end else begin
      m_done = 0;
      if (cmd_abort) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (cmd_arm) begin
               m_len = cfg_capture_len; m_hold = cfg_holdoff; m_rearm = cfg_auto_rearm;
               m_count = 0; m_phase = 1; m_left = CC;
             end
          1: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
             end
          2: if (trigger_activated) m_phase = 3;
          3: if ((m_len != 0 && limiter >= m_len) || !trigger_activated) begin
               m_done = 1;
               if (m_count < (1 << DW) - 1) m_count++;
               if (m_rearm) begin m_phase = 4; m_left = m_hold + 1; end
               else m_phase = 0;
             end
          4: begin
               m_left--;
               if (m_left == 0) begin m_phase = 1; m_left = CC; end
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  always @(negedge aclk) begin
    chk("state", state, m_phase);
    chk("reset_trigger", reset_trigger, (m_phase == 0 || m_phase == 1 || m_phase == 4));
    chk("reset_max_sum", reset_max_sum, (m_phase == 1));
    chk("armed", armed, (m_phase == 2));
    chk("busy", busy, (m_phase != 0));
    chk("capture_done", capture_done, m_done);
    chk("capture_count", capture_count, m_count);
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge aclk);
  endtask

  task automatic arm();
    cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
  endtask

  task automatic abort();
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
  endtask

  task automatic wait_state(logic [2:0] s, string name);
    int n = 0;
    while (state !== s && n < 300) begin tick(); n++; end
    chk(name, state, s);
  endtask

  task automatic ramp(int first, int last);
    for (int l = first; l <= last; l++) begin limiter = l; tick(); end
  endtask

  initial begin
    int n;
    // Reset and quiet idle
    tick(3);
    aresetn = 1'b1;
    tick(100);
    chk("idle_state", state, 0);
    chk("idle_reset_trigger", reset_trigger, 1);
    chk("idle_busy", busy, 0);

    // Arm: CLEAR duration, then ARMED
    cfg_capture_len = 100; cfg_holdoff = 0; cfg_auto_rearm = 1'b0;
    arm();
    n = 0;
    while (reset_max_sum && n < 50) begin n++; tick(); end
    chk("clear_cycles", n, 8);
    chk("armed_state", state, 2);
    chk("armed_flag", armed, 1);
    chk("armed_reset_trigger", reset_trigger, 0);

    // Single bounded capture
    trigger_activated = 1'b1; limiter = 0; tick();
    chk("capture_state", state, 3);
    ramp(1, 99);
    chk("capture_hold", state, 3);
    limiter = 100; tick();
    chk("single_done", capture_done, 1);
    chk("single_count", capture_count, 1);
    chk("single_idle", state, 0);
    chk("single_reset_trigger", reset_trigger, 1);
    trigger_activated = 1'b0; limiter = 0; tick();
    chk("single_done_pulse", capture_done, 0);

    // Auto-rearm with holdoff; config changes after arm must not leak in
    cfg_capture_len = 10; cfg_holdoff = 5; cfg_auto_rearm = 1'b1;
    arm();
    cfg_capture_len = 3; cfg_holdoff = 20; cfg_auto_rearm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_state(2, "rearm_armed");
      trigger_activated = 1'b1; limiter = 0; tick();
      ramp(1, 10);
      trigger_activated = 1'b0; limiter = 0;
      n = 0;
      while (state == 3'd4 && n < 50) begin n++; tick(); end
      chk("holdoff_cycles", n, 6);
      n = 0;
      while (state == 3'd1 && n < 50) begin n++; tick(); end
      chk("reclear_cycles", n, 8);
    end
    chk("rearm_count", capture_count, 3);
    abort();
    chk("abort_armed_idle", state, 0);

    // Abort coinciding with capture end
    cfg_capture_len = 4; cfg_holdoff = 0; cfg_auto_rearm = 1'b1;
    arm();
    wait_state(2, "abort_armed");
    trigger_activated = 1'b1; limiter = 0; tick();
    ramp(1, 4);
    trigger_activated = 1'b0; limiter = 0;
    wait_state(2, "abort_rearmed");
    chk("abort_pre_count", capture_count, 1);
    trigger_activated = 1'b1; tick();
    ramp(1, 3);
    limiter = 4; cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_no_done", capture_done, 0);
    chk("abort_count", capture_count, 1);
    trigger_activated = 1'b0; limiter = 0;

    // Arm while ARMED is ignored
    cfg_auto_rearm = 1'b0;
    arm();
    wait_state(2, "rearm_ignore_armed");
    arm();
    chk("arm_ignored", state, 2);
    abort();

    // Unbounded capture passes 2^20, ends when trigger drops
    cfg_capture_len = 0;
    arm();
    wait_state(2, "unbounded_armed");
    trigger_activated = 1'b1; limiter = 0; tick();
    for (int i = 0; i < 8; i++) begin limiter = 32'h000F_FFFC + i; tick(); end
    limiter = 32'hFFFF_FFFF; tick();
    chk("unbounded_capture", state, 3);
    trigger_activated = 1'b0; tick();
    chk("unbounded_done", capture_done, 1);
    chk("unbounded_idle", state, 0);
    limiter = 0;

    // Asynchronous reset mid-capture
    arm();
    wait_state(2, "areset_armed");
    trigger_activated = 1'b1; tick();
    chk("areset_capture", state, 3);
    #2 aresetn = 1'b0;
    #1;
    chk("areset_state", state, 0);
    chk("areset_reset_trigger", reset_trigger, 1);
    chk("areset_reset_max_sum", reset_max_sum, 0);
    chk("areset_armed", armed, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", capture_done, 0);
    chk("areset_count", capture_count, 0);
    trigger_activated = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(2);

    // Randomized run with an emulated datapath
    for (int c = 0; c < 5000; c++) begin
      tick();
      cmd_arm   = ($urandom_range(0, 11) == 0);
      cmd_abort = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_capture_len = $urandom_range(0, 12);
        cfg_holdoff     = $urandom_range(0, 6);
        cfg_auto_rearm  = 1'($urandom_range(0, 1));
      end
      if (reset_trigger) begin
        trigger_activated = 1'b0; limiter = 0;
      end else if (!trigger_activated) begin
        trigger_activated = ($urandom_range(0, 5) == 0);
      end else begin
        limiter = limiter + 32'd1;
        if ($urandom_range(0, 29) == 0) trigger_activated = 1'b0;
      end
    end
    cmd_arm = 1'b0; cmd_abort = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Control FSM that sequences the ADC trigger/capture datapath. It drives the datapath's reset_trigger and reset_max_sum inputs and watches its trigger_activated flag and limiter count. Software issues arm and abort commands. The block bounds each capture to a programmed sample count and optionally re-arms after a holdoff. It sits between the register bank (command/config) and the ADC trigger datapath.

Parameters:
CLEAR_CYCLES, 8, cycles reset_trigger/reset_max_sum are held in CLEAR; must be >=1
CNT_WIDTH, 32, width of capture-length, holdoff and limiter values
DONE_CNT_WIDTH, 16, width of completed-capture counter

Ports:
aclk  in  1  system clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
cmd_arm  in  1  single-cycle pulse: start acquisition
cmd_abort  in  1  single-cycle pulse: stop and return to IDLE
cfg_capture_len  in  CNT_WIDTH  samples to stream per capture; 0 = unbounded
cfg_holdoff  in  CNT_WIDTH  idle cycles between captures in auto-rearm
cfg_auto_rearm  in  1  1 = re-arm automatically after each capture
trigger_activated  in  1  datapath trigger-fired flag
limiter  in  CNT_WIDTH  datapath count of samples streamed since trigger
reset_trigger  out  1  to datapath: clear trigger state and limiter
reset_max_sum  out  1  to datapath: clear peak detector
state  out  3  current FSM state code
armed  out  1  high in ARMED
busy  out  1  high in any state except IDLE
capture_done  out  1  single-cycle pulse on normal capture completion
capture_count  out  DONE_CNT_WIDTH  completed captures since arm, saturating

Behaviour:
- Reset (async, aresetn low): state=IDLE, reset_trigger=1, reset_max_sum=0, armed=0, busy=0, capture_done=0, capture_count=0, timer=0, latched cfg=0.
- All outputs are registered. Each output reflects the state register value in the same cycle.
- State codes: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, HOLDOFF=4.
- IDLE:
  - Outputs: reset_trigger=1.
  - On cmd_arm: latch cfg_capture_len, cfg_holdoff, cfg_auto_rearm; clear capture_count; timer<=CLEAR_CYCLES-1; go to CLEAR.
- CLEAR:
  - Outputs: reset_trigger=1, reset_max_sum=1.
  - Lasts exactly CLEAR_CYCLES cycles (timer decrements to 0), then goes to ARMED.
- ARMED:
  - Outputs: reset_trigger=0, reset_max_sum=0.
  - trigger_activated==1 -> CAPTURE.
- CAPTURE:
  - Outputs: reset_trigger=0.
  - End condition: (len!=0 and limiter>=len) or trigger_activated==0. The second case covers the datapath's internal limiter cap.
  - On end: capture_done=1 for one cycle. capture_count+1, saturating at all-ones.
  - Then: if auto_rearm, timer<=holdoff and go to HOLDOFF; else go to IDLE.
  - With len=0, the capture ends only on abort or trigger_activated falling.
- HOLDOFF:
  - Outputs: reset_trigger=1.
  - Timer decrements each cycle. At timer==0: timer<=CLEAR_CYCLES-1, go to CLEAR.
  - holdoff=0 therefore means exactly 1 HOLDOFF cycle.
- cmd_abort:
  - In any non-IDLE state: go to IDLE next cycle.
  - No capture_done pulse; capture_count unchanged.
  - Abort wins over arm, timer expiry and capture end in the same cycle.
- cmd_arm when not IDLE: ignored. cmd_arm and cmd_abort together in IDLE: abort wins, stay IDLE.
- Config inputs are used only via the copies latched at arm. Changes mid-acquisition take effect on the next arm.
- Comparisons are unsigned over CNT_WIDTH. Timer never underflows.
- Illegal state codes recover to IDLE.

Decomposition:
- Shared package adc_ctrl_pkg holds:
  - state enum/localparams (IDLE..HOLDOFF, 3-bit)
  - default CLEAR_CYCLES
  - CNT_WIDTH
- One natural sub-module: adc_ctrl_timer, a loadable down-counter with load, enable and zero flag, shared by CLEAR and HOLDOFF.
- Everything else stays in adc_acq_sequencer.

Test Plan:
- Reset release, no commands -> state=0, reset_trigger=1, busy=0 held for 100 cycles.
- cmd_arm, CLEAR_CYCLES=8 -> reset_trigger and reset_max_sum high exactly 8 cycles, then state=2, armed=1, reset_trigger=0.
- Single capture: len=100, auto_rearm=0; raise trigger_activated, ramp limiter 0..100 -> state=3 until limiter=100. Then one capture_done pulse, capture_count=1, state=0, reset_trigger=1.
- Auto-rearm: len=10, holdoff=5, three triggers -> per capture HOLDOFF 6 cycles, CLEAR 8 cycles, ARMED. After third capture, capture_count=3.
- Abort in CAPTURE, same cycle as limiter reaching len -> state=0, no capture_done, capture_count unchanged. cmd_arm during ARMED -> ignored.
- len=0 -> stays CAPTURE while limiter passes 2^20. trigger_activated falling -> capture_done, state=0.
- Async reset asserted mid-CAPTURE -> all outputs take reset values immediately, without waiting for a clock edge.
